// File: rtl/calculadora_param.sv
// calculadora_param: keypad decimal calculator with DIGITS-wide operands,
// iterative mul/div and a digit-serial result stream.
module calculadora_param #(
  parameter int DIGITS = 8,
  parameter int WIDTH  = 32,
  parameter int POS_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       cmd,
  input  logic             cmd_valid,
  output logic [1:0]       status,
  output logic [POS_W-1:0] pos,
  output logic [3:0]       dig,
  output logic             dig_valid,
  output logic             neg
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + DIGITS + 1);

  function automatic logic [PW-1:0] p10(input int n);
    logic [PW-1:0] v;
    v = PW'(1);
    for (int i = 0; i < n; i++)
      v = v * PW'(10);
    return v;
  endfunction

  localparam logic [PW-1:0]    MAXV = p10(DIGITS) - PW'(1);
  localparam logic [WIDTH-1:0] LIM  = WIDTH'(p10(DIGITS - 1));
  localparam logic [WIDTH-1:0] TEN  = WIDTH'(10);

  typedef enum logic [2:0] {
    S_A, A_ENT, S_B, B_ENT, CALC, CHECK, SEND, ERR
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV
  } op_t;

  state_t           state, state_n;
  op_t              op, op_n;
  logic [WIDTH-1:0] a, a_n;
  logic [WIDTH-1:0] b, b_n;
  logic [WIDTH-1:0] mp, mp_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [PW-1:0]    acc, acc_n;
  logic [PW-1:0]    mc, mc_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             neg_n;
  logic             dv_n;
  logic [1:0]       status_n;
  logic [POS_W-1:0] pos_n;
  logic [3:0]       dig_n;
  logic             echo;
  logic [WIDTH:0]   rsh;
  logic [WIDTH-1:0] quo;
  logic             is_dig, is_op, is_eq, is_bk;

  assign is_dig = cmd_valid && (cmd <= 4'd9);
  assign is_op  = cmd_valid && (cmd >= 4'd10) && (cmd <= 4'd13);
  assign is_eq  = cmd_valid && (cmd == 4'd14);
  assign is_bk  = cmd_valid && (cmd == 4'd15);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_A;
      op        <= OP_ADD;
      a         <= '0;
      b         <= '0;
      mp        <= '0;
      rem       <= '0;
      sh        <= '0;
      acc       <= '0;
      mc        <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      status    <= 2'd1;
      pos       <= '0;
      dig       <= '0;
      dig_valid <= 1'b0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      a         <= a_n;
      b         <= b_n;
      mp        <= mp_n;
      rem       <= rem_n;
      sh        <= sh_n;
      acc       <= acc_n;
      mc        <= mc_n;
      cnt       <= cnt_n;
      neg       <= neg_n;
      status    <= status_n;
      pos       <= pos_n;
      dig       <= dig_n;
      dig_valid <= dv_n;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op;
    a_n     = a;
    b_n     = b;
    mp_n    = mp;
    rem_n   = rem;
    sh_n    = sh;
    acc_n   = acc;
    mc_n    = mc;
    cnt_n   = cnt;
    neg_n   = neg;
    pos_n   = pos;
    dig_n   = dig;
    dv_n    = 1'b0;
    echo    = 1'b0;

    // one restoring-division step on the quotient held in acc
    rsh = {rem, acc[WIDTH-1]};
    quo = {acc[WIDTH-2:0], 1'b0};
    if (rsh >= {1'b0, b}) begin
      rsh    = rsh - {1'b0, b};
      quo[0] = 1'b1;
    end

    unique case (state)
      S_A: begin
        if (is_dig) begin
          a_n     = WIDTH'(cmd);
          echo    = 1'b1;
          state_n = A_ENT;
        end
      end
      A_ENT: begin
        unique case (1'b1)
          is_dig: begin
            if (a < LIM) begin
              a_n  = a * TEN + WIDTH'(cmd);
              echo = 1'b1;
            end
          end
          is_bk: a_n = a / TEN;
          is_op: begin
            op_n    = op_t'(cmd[1:0] + 2'd2);
            state_n = S_B;
          end
          default: ;
        endcase
      end
      S_B: begin
        unique case (1'b1)
          is_dig: begin
            b_n     = WIDTH'(cmd);
            echo    = 1'b1;
            state_n = B_ENT;
          end
          is_eq, is_op: state_n = ERR;
          default: ;
        endcase
      end
      B_ENT: begin
        unique case (1'b1)
          is_dig: begin
            if (b < LIM) begin
              b_n  = b * TEN + WIDTH'(cmd);
              echo = 1'b1;
            end
          end
          is_bk: b_n = b / TEN;
          is_eq: begin
            cnt_n   = '0;
            mc_n    = PW'(a);
            mp_n    = b;
            rem_n   = '0;
            acc_n   = (op == OP_DIV) ? PW'(a) : '0;
            state_n = CALC;
          end
          is_op: state_n = ERR;
          default: ;
        endcase
      end
      CALC: begin
        unique case (op)
          OP_ADD: begin
            acc_n   = PW'(a) + PW'(b);
            state_n = CHECK;
          end
          OP_SUB: begin
            if (a >= b) begin
              acc_n = PW'(a - b);
              neg_n = 1'b0;
            end else begin
              acc_n = PW'(b - a);
              neg_n = 1'b1;
            end
            state_n = CHECK;
          end
          OP_MUL: begin
            if (mp[0])
              acc_n = acc + mc;
            mc_n  = mc << 1;
            mp_n  = mp >> 1;
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1))
              state_n = CHECK;
          end
          OP_DIV: begin
            if (cnt == '0 && b == '0) begin
              state_n = ERR;
            end else begin
              rem_n = rsh[WIDTH-1:0];
              acc_n = PW'(quo);
              cnt_n = cnt + CW'(1);
              if (cnt == CW'(WIDTH - 1))
                state_n = CHECK;
            end
          end
          default: ;
        endcase
      end
      CHECK: begin
        if (acc > MAXV) begin
          state_n = ERR;
        end else begin
          sh_n    = acc[WIDTH-1:0];
          cnt_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (cnt == CW'(DIGITS)) begin
          neg_n   = 1'b0;
          a_n     = '0;
          b_n     = '0;
          op_n    = OP_ADD;
          state_n = S_A;
        end else begin
          dig_n = 4'(sh % TEN);
          sh_n  = sh / TEN;
          pos_n = POS_W'(DIGITS - 1) - POS_W'(cnt);
          dv_n  = 1'b1;
          cnt_n = cnt + CW'(1);
        end
      end
      ERR: begin
        if (is_bk) begin
          a_n     = '0;
          b_n     = '0;
          op_n    = OP_ADD;
          neg_n   = 1'b0;
          state_n = S_A;
        end
      end
      default: state_n = S_A;
    endcase

    if (echo) begin
      dig_n = cmd;
      pos_n = '0;
      dv_n  = 1'b1;
    end

    unique case (state_n)
      S_A:     status_n = 2'd1;
      ERR:     status_n = 2'd0;
      default: status_n = 2'd2;
    endcase
  end

endmodule
